// File: rtl/prefetch_unit_if.sv
// -----------------------------------------------------------------------------
// prefetch_unit_if
// Instruction-memory bus between the prefetch unit and the instruction memory.
//   imem_req_valid  : fetch request (prefetch unit -> memory)
//   imem_req_addr   : fetch address (prefetch unit -> memory)
//   imem_req_ready  : memory accepts the request (memory -> prefetch unit)
//   imem_rsp_valid  : in-order response strobe (memory -> prefetch unit)
//   imem_rsp_data   : response instruction word (memory -> prefetch unit)
// Modports: master = prefetch unit side, slave = memory side.
// -----------------------------------------------------------------------------
interface prefetch_unit_if #(
   parameter int PC_W    = 32,
   parameter int INSTR_W = 26
);
   logic               imem_req_valid;
   logic [PC_W-1:0]    imem_req_addr;
   logic               imem_req_ready;
   logic               imem_rsp_valid;
   logic [INSTR_W-1:0] imem_rsp_data;

   modport master (
      output imem_req_valid,
      output imem_req_addr,
      input  imem_req_ready,
      input  imem_rsp_valid,
      input  imem_rsp_data
   );

   modport slave (
      input  imem_req_valid,
      input  imem_req_addr,
      output imem_req_ready,
      output imem_rsp_valid,
      output imem_rsp_data
   );
endinterface

// File: rtl/prefetch_unit.sv
// -----------------------------------------------------------------------------
// prefetch_unit
// Instruction prefetcher: issues sequential fetches to an in-order instruction
// memory, buffers responses in a DEPTH-entry queue and feeds a decode register.
// Redirects restart fetch at a new target and discard every response still in
// flight at that moment.
// Ports:
//   clk, reset              : clock, asynchronous active-high reset
//   redir_e / redir_e_pc    : execute-stage redirect (higher priority)
//   redir_w / redir_w_pc    : writeback-stage redirect
//   stall_f                 : blocks new memory requests
//   stall_d / flush_d       : hold / invalidate the decode register
//   imem                    : instruction-memory bus (master side)
//   instr_d, pc_plus_d,
//   valid_d                 : decode-stage instruction, its pc + 4, valid flag
// -----------------------------------------------------------------------------
module prefetch_unit #(
   parameter int              PC_W     = 32,
   parameter int              INSTR_W  = 26,
   parameter int              DEPTH    = 4,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               redir_w,
   input  logic [PC_W-1:0]    redir_w_pc,
   input  logic               redir_e,
   input  logic [PC_W-1:0]    redir_e_pc,
   input  logic               stall_f,
   input  logic               stall_d,
   input  logic               flush_d,
   prefetch_unit_if.master    imem,
   output logic [INSTR_W-1:0] instr_d,
   output logic [PC_W-1:0]    pc_plus_d,
   output logic               valid_d
);
   localparam int              AW      = $clog2(DEPTH);
   localparam int              CW      = $clog2(DEPTH + 1);
   localparam logic [CW:0]     DEPTH_C = (CW + 1)'(DEPTH);
   localparam logic [PC_W-1:0] STEP    = PC_W'(4);

   logic [PC_W-1:0]    fetch_pc;
   logic [PC_W-1:0]    rsp_pc;
   logic [CW-1:0]      outstanding;
   logic [CW-1:0]      drop_cnt;
   logic [CW-1:0]      q_count;
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [INSTR_W-1:0] q_data [DEPTH];
   logic [PC_W-1:0]    q_pc   [DEPTH];

   logic               redirect;
   logic [PC_W-1:0]    redir_pc;
   logic [CW:0]        inflight;
   logic               req_valid;
   logic               accept;
   logic               rsp_keep;
   logic               deq;

   always_comb begin
      redirect  = redir_e | redir_w;
      redir_pc  = redir_e ? redir_e_pc : redir_w_pc;
      // Queued plus outstanding never exceeds DEPTH, so every response has a slot.
      inflight  = {1'b0, q_count} + {1'b0, outstanding};
      req_valid = !stall_f && !redirect && (inflight < DEPTH_C);
      accept    = req_valid && imem.imem_req_ready;
      // A response is discarded if it belongs to a pre-redirect request.
      rsp_keep  = imem.imem_rsp_valid && !redirect && (drop_cnt == '0);
      deq       = !redirect && !flush_d && !stall_d && (q_count != '0);
   end

   assign imem.imem_req_valid = req_valid;
   assign imem.imem_req_addr  = fetch_pc;

   // Fetch / response tracking
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc    <= RESET_PC;
         rsp_pc      <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         if (redirect) begin
            fetch_pc <= redir_pc;
            rsp_pc   <= redir_pc;
            // Every request still outstanding is stale, including those that
            // were already scheduled for dropping; a response arriving now
            // retires one of them immediately.
            drop_cnt <= outstanding - CW'(imem.imem_rsp_valid);
         end else begin
            if (accept) begin
               fetch_pc <= fetch_pc + STEP;
            end
            if (rsp_keep) begin
               rsp_pc <= rsp_pc + STEP;
            end
            if (imem.imem_rsp_valid && (drop_cnt != '0)) begin
               drop_cnt <= drop_cnt - CW'(1);
            end
         end
         case ({accept, imem.imem_rsp_valid})
            2'b10:   outstanding <= outstanding + CW'(1);
            2'b01:   outstanding <= outstanding - CW'(1);
            default: ;
         endcase
      end
   end

   // Instruction queue control
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         q_count <= '0;
      end else if (redirect) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         q_count <= '0;
      end else begin
         if (rsp_keep) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (deq) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({rsp_keep, deq})
            2'b10:   q_count <= q_count + CW'(1);
            2'b01:   q_count <= q_count - CW'(1);
            default: ;
         endcase
      end
   end

   // Queue storage: contents are meaningless while q_count says empty.
   always_ff @(posedge clk) begin
      if (rsp_keep) begin
         q_data[wr_ptr] <= imem.imem_rsp_data;
         q_pc[wr_ptr]   <= rsp_pc;
      end
   end

   // Decode register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_d   <= 1'b0;
         instr_d   <= '0;
         pc_plus_d <= '0;
      end else if (flush_d) begin
         valid_d   <= 1'b0;
         instr_d   <= '0;
         pc_plus_d <= '0;
      end else if (!stall_d) begin
         if (deq) begin
            valid_d   <= 1'b1;
            instr_d   <= q_data[rd_ptr];
            pc_plus_d <= q_pc[rd_ptr] + STEP;
         end else begin
            valid_d <= 1'b0;
            instr_d <= '0;
         end
      end
   end
endmodule

// File: tb/tb_prefetch_unit.sv
// -----------------------------------------------------------------------------
// tb_prefetch_unit
// Bench for prefetch_unit: a directed vector table for streaming and decode
// stall saturation, hand-written sequences for redirects, flush and
// asynchronous reset, then randomized traffic against a queue-based model.
// -----------------------------------------------------------------------------
module tb_prefetch_unit;
   localparam int              PC_W     = 32;
   localparam int              INSTR_W  = 26;
   localparam int              DEPTH    = 4;
   localparam logic [PC_W-1:0] RESET_PC = 32'h0;

   logic               clk = 1'b0;
   logic               reset;
   logic               redir_w, redir_e, stall_f, stall_d, flush_d;
   logic [PC_W-1:0]    redir_w_pc, redir_e_pc, pc_plus_d;
   logic [INSTR_W-1:0] instr_d;
   logic               valid_d;

   prefetch_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) imem ();

   prefetch_unit #(
      .PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
   ) dut (
      .clk(clk), .reset(reset),
      .redir_w(redir_w), .redir_w_pc(redir_w_pc),
      .redir_e(redir_e), .redir_e_pc(redir_e_pc),
      .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
      .imem(imem),
      .instr_d(instr_d), .pc_plus_d(pc_plus_d), .valid_d(valid_d)
   );

   always #5 clk = ~clk;

   // Requests in flight at the memory, oldest first; drop marks stale ones.
   typedef struct { logic [PC_W-1:0] addr; bit drop; int cyc; } fl_t;
   // Instructions buffered between memory and decode.
   typedef struct { logic [INSTR_W-1:0] data; logic [PC_W-1:0] pc; } qe_t;
   typedef struct { bit sd; bit rv; logic [PC_W-1:0] addr; bit vd; logic [PC_W-1:0] pcp; } vec_t;

   fl_t                fl_q[$];
   qe_t                iq[$];
   logic [PC_W-1:0]    m_fpc, m_pcp;
   logic [INSTR_W-1:0] m_instr;
   bit                 m_vld;
   int                 cyc, total, bad;
   vec_t               tbl [17];

   function automatic logic [INSTR_W-1:0] instr_of(input logic [PC_W-1:0] a);
      return INSTR_W'(a >> 2) ^ 26'h2AA_AAAA;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h cycle=%0d", nm, act, exp, cyc);
      end
   endtask

   task automatic drive(input bit sf, input bit sd, input bit fd,
                        input bit re, input logic [PC_W-1:0] epc,
                        input bit rw, input logic [PC_W-1:0] wpc,
                        input bit rdy, input bit go);
      stall_f    = sf;
      stall_d    = sd;
      flush_d    = fd;
      redir_e    = re;
      redir_e_pc = epc;
      redir_w    = rw;
      redir_w_pc = wpc;
      imem.imem_req_ready = rdy;
      // In-order memory: answers the oldest request at least one cycle later.
      if (go && fl_q.size() > 0 && fl_q[0].cyc < cyc) begin
         imem.imem_rsp_valid = 1'b1;
         imem.imem_rsp_data  = instr_of(fl_q[0].addr);
      end else begin
         imem.imem_rsp_valid = 1'b0;
         imem.imem_rsp_data  = '0;
      end
   endtask

   task automatic drive_norm();
      drive(0, 0, 0, 0, '0, 0, '0, 1, 1);
   endtask

   // One clock cycle: check the request, advance the model at the edge,
   // then check the decode register.
   task automatic step();
      bit              redirect, acc, exp_rv, rsp;
      logic [PC_W-1:0] acc_addr;
      fl_t             f;
      qe_t             e;
      #1;
      redirect = redir_e || redir_w;
      exp_rv   = !stall_f && !redirect && ((iq.size() + fl_q.size()) < DEPTH);
      chk("req_valid", imem.imem_req_valid, exp_rv);
      chk("req_addr", imem.imem_req_addr, m_fpc);
      acc      = (imem.imem_req_valid === 1'b1) && imem.imem_req_ready;
      acc_addr = imem.imem_req_addr;
      rsp      = imem.imem_rsp_valid;
      @(posedge clk);
      if (flush_d) begin
         m_vld = 0; m_instr = '0; m_pcp = '0;
      end else if (!stall_d) begin
         if (!redirect && iq.size() > 0) begin
            e = iq.pop_front();
            m_vld = 1; m_instr = e.data; m_pcp = e.pc + 4;
         end else begin
            m_vld = 0; m_instr = '0;
         end
      end
      if (rsp && fl_q.size() > 0) begin
         f = fl_q.pop_front();
         if (!f.drop && !redirect) iq.push_back('{instr_of(f.addr), f.addr});
      end
      if (redirect) begin
         iq.delete();
         foreach (fl_q[i]) fl_q[i].drop = 1;
         m_fpc = redir_e ? redir_e_pc : redir_w_pc;
      end else if (acc) begin
         m_fpc = m_fpc + 4;
      end
      if (acc) fl_q.push_back('{acc_addr, 1'b0, cyc});
      cyc++;
      @(negedge clk);
      chk("valid_d", valid_d, m_vld);
      chk("instr_d", instr_d, m_instr);
      chk("pc_plus_d", pc_plus_d, m_pcp);
   endtask

   // Entered at a falling edge; reset rises between clock edges.
   task automatic async_reset();
      #2 reset = 1'b1;
      #1;
      chk("areset valid_d", valid_d, 1'b0);
      chk("areset instr_d", instr_d, '0);
      chk("areset pc_plus_d", pc_plus_d, '0);
      fl_q.delete(); iq.delete();
      m_fpc = RESET_PC; m_vld = 0; m_instr = '0; m_pcp = '0;
      imem.imem_rsp_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      total = 0; bad = 0; cyc = 0;
      m_fpc = RESET_PC; m_vld = 0; m_instr = '0; m_pcp = '0;
      reset = 1'b1;
      drive(0, 0, 0, 0, '0, 0, '0, 1, 0);

      // Streaming with a 1-cycle memory, then 6 decode-stall cycles.
      tbl = '{
         '{0, 1, 32'd0,  0, 32'd0},  '{0, 1, 32'd4,  0, 32'd0},
         '{0, 1, 32'd8,  0, 32'd0},  '{0, 1, 32'd12, 1, 32'd4},
         '{0, 1, 32'd16, 1, 32'd8},  '{0, 1, 32'd20, 1, 32'd12},
         '{1, 1, 32'd24, 1, 32'd16}, '{1, 1, 32'd28, 1, 32'd16},
         '{1, 0, 32'd32, 1, 32'd16}, '{1, 0, 32'd32, 1, 32'd16},
         '{1, 0, 32'd32, 1, 32'd16}, '{1, 0, 32'd32, 1, 32'd16},
         '{0, 0, 32'd32, 1, 32'd16}, '{0, 1, 32'd32, 1, 32'd20},
         '{0, 1, 32'd36, 1, 32'd24}, '{0, 1, 32'd40, 1, 32'd28},
         '{0, 1, 32'd44, 1, 32'd32}
      };

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset valid_d", valid_d, 1'b0);
      chk("reset instr_d", instr_d, '0);
      chk("reset pc_plus_d", pc_plus_d, '0);
      chk("reset req_addr", imem.imem_req_addr, RESET_PC);
      reset = 1'b0;

      for (int i = 0; i < 17; i++) begin
         drive(0, tbl[i].sd, 0, 0, '0, 0, '0, 1, 1);
         #1;
         chk("tbl req_valid", imem.imem_req_valid, tbl[i].rv);
         chk("tbl req_addr", imem.imem_req_addr, tbl[i].addr);
         chk("tbl valid_d", valid_d, tbl[i].vd);
         chk("tbl pc_plus_d", pc_plus_d, tbl[i].pcp);
         chk("tbl instr_d", instr_d, tbl[i].vd ? instr_of(tbl[i].pcp - 4) : '0);
         step();
      end

      // Two requests outstanding, then an execute redirect to 0x100.
      drive(0, 0, 0, 0, '0, 0, '0, 1, 0);
      step();
      drive(0, 0, 0, 1, 32'h100, 0, '0, 1, 1);
      #1;
      chk("redir cycle req_valid", imem.imem_req_valid, 1'b0);
      step();
      drive_norm();
      #1;
      chk("post redir req_valid", imem.imem_req_valid, 1'b1);
      chk("post redir req_addr", imem.imem_req_addr, 32'h100);
      step();
      seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         if (valid_d === 1'b1) begin
            seen = 1;
            chk("first pc after redir", pc_plus_d, 32'h104);
         end else begin
            drive_norm();
            step();
         end
      end
      if (!seen) chk("redir valid_d timeout", 1'b0, 1'b1);

      // Simultaneous execute and writeback redirects: execute wins.
      drive(0, 0, 0, 1, 32'h200, 1, 32'h300, 1, 1);
      step();
      drive_norm();
      #1;
      chk("dual redir req_addr", imem.imem_req_addr, 32'h200);
      step();

      // Flush together with stall: decode empties, queue keeps its entries.
      for (int k = 0; k < 3; k++) begin
         drive(0, 1, 0, 0, '0, 0, '0, 1, 1);
         step();
      end
      drive(0, 1, 1, 0, '0, 0, '0, 1, 1);
      step();
      chk("flush valid_d", valid_d, 1'b0);
      chk("flush pc_plus_d", pc_plus_d, '0);
      drive_norm();
      step();
      chk("after flush valid_d", valid_d, 1'b1);

      // Asynchronous reset mid-stream.
      for (int k = 0; k < 3; k++) begin
         drive_norm();
         step();
      end
      async_reset();
      drive_norm();
      #1;
      chk("post reset req_valid", imem.imem_req_valid, 1'b1);
      chk("post reset req_addr", imem.imem_req_addr, RESET_PC);
      step();

      // Randomized traffic.
      for (int n = 0; n < 2000; n++) begin
         logic [PC_W-1:0] epc, wpc;
         epc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'hFFFF_FFFC);
         wpc = $urandom & 32'hFFFF_FFFC;
         drive($urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 19) == 0,
               $urandom_range(0, 24) == 0, epc,
               $urandom_range(0, 24) == 0, wpc,
               $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7);
         step();
         if (n == 1000) begin
            async_reset();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
